// File: rtl/inorder_resp_merger_if.sv
// Bundle of allocation, bank-response and in-order output signals
// for inorder_resp_merger; slave is the merger, master drives it.
interface inorder_resp_merger_if #(
    parameter int SRC_COUNT = 4,
    parameter int DES_COUNT = 4,
    parameter int OUT_COUNT = 2,
    parameter int DATA_W    = 64
);
    localparam int DW = (DES_COUNT > 1) ? $clog2(DES_COUNT) : 1;

    logic [SRC_COUNT-1:0]                 alloc_vld_i;
    logic [DES_COUNT-1:0][SRC_COUNT-1:0]  alloc_des_sel_i;
    logic                                 alloc_rdy_o;
    logic [DES_COUNT-1:0]                 des_resp_vld_i;
    logic [DES_COUNT-1:0][DATA_W-1:0]     des_resp_data_i;
    logic [DES_COUNT-1:0]                 des_resp_rdy_o;
    logic [OUT_COUNT-1:0]                 out_vld_o;
    logic [OUT_COUNT-1:0][DATA_W-1:0]     out_data_o;
    logic [OUT_COUNT-1:0][DW-1:0]         out_des_o;
    logic [OUT_COUNT-1:0]                 out_rdy_i;

    modport slave (
        input  alloc_vld_i, alloc_des_sel_i,
        input  des_resp_vld_i, des_resp_data_i,
        input  out_rdy_i,
        output alloc_rdy_o, des_resp_rdy_o,
        output out_vld_o, out_data_o, out_des_o
    );

    modport master (
        output alloc_vld_i, alloc_des_sel_i,
        output des_resp_vld_i, des_resp_data_i,
        output out_rdy_i,
        input  alloc_rdy_o, des_resp_rdy_o,
        input  out_vld_o, out_data_o, out_des_o
    );
endinterface

// File: rtl/inorder_resp_merger.sv
// Re-orders per-bank responses into program order via a bank-index FIFO.
// Optional checker: define INORDER_RESP_MERGER_ERR_CHK_EN to add err_o.
module inorder_resp_merger #(
    parameter int SRC_COUNT = 4,
    parameter int DES_COUNT = 4,
    parameter int OUT_COUNT = 2,
    parameter int DEPTH     = 16,
    parameter int DATA_W    = 64
) (
    input  logic clk,
    input  logic rst,
    inorder_resp_merger_if.slave bus
`ifdef INORDER_RESP_MERGER_ERR_CHK_EN
    ,
    output logic err_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int DW = (DES_COUNT > 1) ? $clog2(DES_COUNT) : 1;

    typedef logic [PW:0]   ptr_t;
    typedef logic [DW-1:0] des_t;

    des_t                 mem [DEPTH];
    ptr_t                 head, tail, cnt;
    ptr_t                 push_n, pop_n;
    logic                 alloc_rdy;
    logic [SRC_COUNT-1:0] lane_push;
    des_t                 lane_des [SRC_COUNT];
    logic [PW-1:0]        wr_idx [SRC_COUNT];
    des_t                 rd_des [OUT_COUNT];
    logic [OUT_COUNT-1:0] vld, fire;

    assign alloc_rdy       = (cnt <= ptr_t'(DEPTH - SRC_COUNT));
    assign bus.alloc_rdy_o = alloc_rdy;
    assign bus.out_vld_o   = vld;

    // Decode each source column and compact valid pushes toward tail.
    always_comb begin
        push_n = '0;
        for (int s = 0; s < SRC_COUNT; s++) begin
            int sel_n;
            sel_n        = 0;
            lane_des[s]  = '0;
            lane_push[s] = 1'b0;
            wr_idx[s]    = tail[PW-1:0] + push_n[PW-1:0];
            for (int d = 0; d < DES_COUNT; d++) begin
                if (bus.alloc_des_sel_i[d][s]) begin
                    sel_n++;
                    lane_des[s] = des_t'(d);
                end
            end
            if (alloc_rdy && bus.alloc_vld_i[s] && sel_n == 1) begin
                lane_push[s] = 1'b1;
                push_n       = push_n + ptr_t'(1);
            end
        end
    end

    // Order storage; stale entries are never read, so no reset needed.
    always_ff @(posedge clk) begin
        for (int s = 0; s < SRC_COUNT; s++) begin
            if (lane_push[s]) mem[wr_idx[s]] <= lane_des[s];
        end
    end

    // Build the valid prefix, the firing prefix and bank acknowledges.
    always_comb begin
        logic prev_v, prev_f, ok;
        vld                 = '0;
        fire                = '0;
        pop_n               = '0;
        bus.des_resp_rdy_o  = '0;
        bus.out_data_o      = '0;
        bus.out_des_o       = '0;
        prev_v              = 1'b1;
        prev_f              = 1'b1;
        for (int k = 0; k < OUT_COUNT; k++) begin
            rd_des[k]         = mem[head[PW-1:0] + PW'(k)];
            bus.out_des_o[k]  = rd_des[k];
            bus.out_data_o[k] = bus.des_resp_data_i[rd_des[k]];
            ok = prev_v && (ptr_t'(k) < cnt)
                 && bus.des_resp_vld_i[rd_des[k]];
            for (int j = 0; j < k; j++) begin
                if (rd_des[j] == rd_des[k]) ok = 1'b0;
            end
            vld[k]  = ok;
            fire[k] = ok && prev_f && bus.out_rdy_i[k];
            prev_v  = ok;
            prev_f  = fire[k];
            if (fire[k]) begin
                bus.des_resp_rdy_o[rd_des[k]] = 1'b1;
                pop_n = pop_n + ptr_t'(1);
            end
        end
    end

    // Pointer and occupancy update; reset drops all outstanding entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + pop_n;
            tail <= tail + push_n;
            cnt  <= cnt + push_n - pop_n;
        end
    end

`ifdef INORDER_RESP_MERGER_ERR_CHK_EN
    ptr_t out_cnt [DES_COUNT];
    ptr_t bank_inc [DES_COUNT];
    ptr_t bank_dec [DES_COUNT];
    logic err_hit;

    // Per-bank traffic and protocol violation detection.
    always_comb begin
        err_hit = 1'b0;
        for (int d = 0; d < DES_COUNT; d++) begin
            bank_inc[d] = '0;
            bank_dec[d] = '0;
            for (int s = 0; s < SRC_COUNT; s++) begin
                if (lane_push[s] && lane_des[s] == des_t'(d))
                    bank_inc[d] = bank_inc[d] + ptr_t'(1);
            end
            for (int k = 0; k < OUT_COUNT; k++) begin
                if (fire[k] && rd_des[k] == des_t'(d))
                    bank_dec[d] = bank_dec[d] + ptr_t'(1);
            end
            if (bus.des_resp_vld_i[d] && out_cnt[d] == '0)
                err_hit = 1'b1;
        end
        for (int s = 0; s < SRC_COUNT; s++) begin
            int n;
            n = 0;
            for (int d = 0; d < DES_COUNT; d++) begin
                if (bus.alloc_des_sel_i[d][s]) n++;
            end
            if (n > 1) err_hit = 1'b1;
        end
    end

    // Outstanding counters and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < DES_COUNT; d++) out_cnt[d] <= '0;
            err_o <= 1'b0;
        end else begin
            for (int d = 0; d < DES_COUNT; d++)
                out_cnt[d] <= out_cnt[d] + bank_inc[d] - bank_dec[d];
            err_o <= err_o | err_hit;
        end
    end
`endif
endmodule

// File: tb/tb_inorder_resp_merger.sv
// Scoreboard bench for inorder_resp_merger (4 src, 4 banks, 2 out, 16 deep).
// Define INORDER_RESP_MERGER_ERR_CHK_EN to also exercise err_o.
module tb_inorder_resp_merger;
    localparam int S  = 4;
    localparam int D  = 4;
    localparam int O  = 2;
    localparam int DP = 16;
    localparam int W  = 64;

    typedef struct {
        logic [1:0]   des;
        logic [W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
`ifdef INORDER_RESP_MERGER_ERR_CHK_EN
    logic err_o;
`endif

    int checks = 0;
    int fails  = 0;
    int tag    = 0;

    ent_t         exp_q[$];
    logic [W-1:0] bank_q[D][$];

    always #5 clk = ~clk;

    inorder_resp_merger_if #(
        .SRC_COUNT(S), .DES_COUNT(D), .OUT_COUNT(O), .DATA_W(W)
    ) bus ();

    inorder_resp_merger #(
        .SRC_COUNT(S), .DES_COUNT(D), .OUT_COUNT(O),
        .DEPTH(DP), .DATA_W(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef INORDER_RESP_MERGER_ERR_CHK_EN
        ,
        .err_o(err_o)
`endif
    );

    task automatic refresh_data();
        for (int d = 0; d < D; d++)
            bus.des_resp_data_i[d] = (bank_q[d].size() > 0) ?
                bank_q[d][0] : 64'hBAD0_0000_0000_0000 + 64'(d);
    endtask

    function automatic void model_out(output logic [O-1:0] mv,
                                      output logic [D-1:0] mr,
                                      output int mp);
        logic [D-1:0] seen;
        bit ok;
        seen = '0; mv = '0; mr = '0; mp = 0; ok = 1;
        for (int k = 0; k < O; k++) begin
            if (ok && k < exp_q.size() &&
                bus.des_resp_vld_i[exp_q[k].des] && !seen[exp_q[k].des]) begin
                mv[k] = 1'b1;
                seen[exp_q[k].des] = 1'b1;
            end else ok = 0;
        end
        ok = 1;
        for (int k = 0; k < O; k++) begin
            if (ok && mv[k] && bus.out_rdy_i[k]) begin
                mr[exp_q[k].des] = 1'b1;
                mp++;
            end else ok = 0;
        end
    endfunction

    task automatic tick();
        logic [O-1:0] mv;
        logic [D-1:0] mr;
        int mp;
        bit rdy;
        model_out(mv, mr, mp);
        rdy = exp_q.size() <= DP - S;
        for (int k = 0; k < mp; k++) begin
            void'(bank_q[exp_q[0].des].pop_front());
            void'(exp_q.pop_front());
        end
        if (rdy) begin
            for (int s = 0; s < S; s++) begin
                int n;
                int sd;
                n = 0; sd = 0;
                for (int d = 0; d < D; d++)
                    if (bus.alloc_des_sel_i[d][s]) begin n++; sd = d; end
                if (bus.alloc_vld_i[s] && n == 1) begin
                    ent_t e;
                    e.des  = 2'(sd);
                    e.data = 64'hD000_0000_0000_0000 + 64'(tag);
                    tag++;
                    exp_q.push_back(e);
                    bank_q[sd].push_back(e.data);
                end
            end
        end
        @(posedge clk);
        #1;
        refresh_data();
    endtask

    task automatic clear_inputs();
        bus.alloc_vld_i     = '0;
        bus.alloc_des_sel_i = '0;
        bus.des_resp_vld_i  = '0;
        bus.out_rdy_i       = '0;
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int d = 0; d < D; d++) bank_q[d].delete();
        refresh_data();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_alloc(input logic [S-1:0] v, input int b0,
                             input int b1, input int b2, input int b3);
        int b[S];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        bus.alloc_vld_i     = v;
        bus.alloc_des_sel_i = '0;
        for (int s = 0; s < S; s++)
            if (b[s] >= 0) bus.alloc_des_sel_i[b[s]][s] = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        clear_model();
        #3;
        checks++;
        if (bus.alloc_rdy_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_alloc_rdy got %b want 1", bus.alloc_rdy_o);
        end
        checks++;
        if (bus.out_vld_o !== 2'b00) begin
            fails++;
            $display("FAIL reset_out_vld got %b want 00", bus.out_vld_o);
        end
        checks++;
        if (bus.des_resp_rdy_o !== 4'b0000) begin
            fails++;
            $display("FAIL reset_resp_rdy got %b want 0000",
                     bus.des_resp_rdy_o);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        set_alloc(4'b1111, 2, 0, 1, 3);
        bus.des_resp_vld_i = 4'b1111;
        bus.out_rdy_i      = 2'b11;
        @(negedge clk);
        checks++;
        if (bus.out_vld_o !== 2'b00 || bus.des_resp_rdy_o !== 4'b0000) begin
            fails++;
            $display("FAIL basic_empty vld %b rdy %b want 00 0000",
                     bus.out_vld_o, bus.des_resp_rdy_o);
        end
        tick();
        set_alloc(4'b0000, -1, -1, -1, -1);
        @(negedge clk);
        checks++;
        if (bus.out_vld_o !== 2'b11 || bus.out_des_o[0] !== 2'd2 ||
            bus.out_des_o[1] !== 2'd0 || bus.des_resp_rdy_o !== 4'b0101) begin
            fails++;
            $display("FAIL basic_c1 vld %b des %0d,%0d rdy %b want 11 2,0 0101",
                     bus.out_vld_o, bus.out_des_o[0], bus.out_des_o[1],
                     bus.des_resp_rdy_o);
        end
        checks++;
        if (bus.out_data_o[0] !== exp_q[0].data ||
            bus.out_data_o[1] !== exp_q[1].data) begin
            fails++;
            $display("FAIL basic_c1_data got %h %h want %h %h",
                     bus.out_data_o[0], bus.out_data_o[1],
                     exp_q[0].data, exp_q[1].data);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.out_vld_o !== 2'b11 || bus.out_des_o[0] !== 2'd1 ||
            bus.out_des_o[1] !== 2'd3 || bus.des_resp_rdy_o !== 4'b1010) begin
            fails++;
            $display("FAIL basic_c2 vld %b des %0d,%0d rdy %b want 11 1,3 1010",
                     bus.out_vld_o, bus.out_des_o[0], bus.out_des_o[1],
                     bus.des_resp_rdy_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.out_vld_o !== 2'b00 || bus.alloc_rdy_o !== 1'b1) begin
            fails++;
            $display("FAIL basic_drained vld %b alloc_rdy %b want 00 1",
                     bus.out_vld_o, bus.alloc_rdy_o);
        end
    endtask

    task automatic test_same_bank();
        do_reset();
        set_alloc(4'b0011, 1, 1, -1, -1);
        tick();
        set_alloc(4'b0000, -1, -1, -1, -1);
        bus.des_resp_vld_i = 4'b0010;
        bus.out_rdy_i      = 2'b11;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out_vld_o !== 2'b01 || bus.des_resp_rdy_o !== 4'b0010 ||
                bus.out_data_o[0] !== exp_q[0].data) begin
                fails++;
                $display("FAIL same_bank_c%0d vld %b rdy %b data %h want 01 0010 %h",
                         c, bus.out_vld_o, bus.des_resp_rdy_o,
                         bus.out_data_o[0], exp_q[0].data);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (bus.out_vld_o !== 2'b00) begin
            fails++;
            $display("FAIL same_bank_drained vld %b want 00", bus.out_vld_o);
        end
    endtask

    task automatic test_head_block();
        do_reset();
        set_alloc(4'b0011, 2, 0, -1, -1);
        tick();
        set_alloc(4'b0000, -1, -1, -1, -1);
        bus.des_resp_vld_i = 4'b0001;
        bus.out_rdy_i      = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out_vld_o !== 2'b00 || bus.des_resp_rdy_o !== 4'b0000) begin
                fails++;
                $display("FAIL head_block_c%0d vld %b rdy %b want 00 0000",
                         c, bus.out_vld_o, bus.des_resp_rdy_o);
            end
            tick();
        end
        bus.des_resp_vld_i = 4'b0101;
        @(negedge clk);
        checks++;
        if (bus.out_vld_o !== 2'b11 || bus.des_resp_rdy_o !== 4'b0101 ||
            bus.out_des_o[0] !== 2'd2 || bus.out_des_o[1] !== 2'd0) begin
            fails++;
            $display("FAIL head_release vld %b rdy %b des %0d,%0d want 11 0101 2,0",
                     bus.out_vld_o, bus.des_resp_rdy_o,
                     bus.out_des_o[0], bus.out_des_o[1]);
        end
        tick();
    endtask

    task automatic test_full();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_alloc(4'b1111, 0, 1, 2, 3);
            tick();
        end
        set_alloc(4'b0001, 0, -1, -1, -1);
        @(negedge clk);
        checks++;
        if (bus.alloc_rdy_o !== 1'b1) begin
            fails++;
            $display("FAIL full_cnt12_rdy got %b want 1", bus.alloc_rdy_o);
        end
        tick();
        set_alloc(4'b1111, 3, 2, 1, 0);
        @(negedge clk);
        checks++;
        if (bus.alloc_rdy_o !== 1'b0) begin
            fails++;
            $display("FAIL full_cnt13_rdy got %b want 0", bus.alloc_rdy_o);
        end
        tick();
        set_alloc(4'b0000, -1, -1, -1, -1);
        bus.des_resp_vld_i = 4'b1111;
        bus.out_rdy_i      = 2'b11;
        @(negedge clk);
        checks++;
        if (bus.out_vld_o !== 2'b11 || bus.out_des_o[0] !== 2'd0 ||
            bus.out_des_o[1] !== 2'd1) begin
            fails++;
            $display("FAIL full_pop2 vld %b des %0d,%0d want 11 0,1",
                     bus.out_vld_o, bus.out_des_o[0], bus.out_des_o[1]);
        end
        tick();
        bus.des_resp_vld_i = 4'b0000;
        @(negedge clk);
        checks++;
        if (bus.alloc_rdy_o !== 1'b1) begin
            fails++;
            $display("FAIL full_cnt11_rdy got %b want 1", bus.alloc_rdy_o);
        end
        bus.des_resp_vld_i = 4'b1111;
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) tick();
        @(negedge clk);
        checks++;
        if (bus.out_vld_o !== 2'b00 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL full_drain vld %b left %0d want 00 0",
                     bus.out_vld_o, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [O-1:0] mv;
        logic [D-1:0] mr;
        int mp;
        int bad;
        bad = 0;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            bus.alloc_vld_i     = (c < 40) ? 4'($urandom) : 4'b0000;
            bus.alloc_des_sel_i = '0;
            for (int s = 0; s < S; s++)
                if ($urandom_range(0, 4) != 0)
                    bus.alloc_des_sel_i[$urandom_range(0, D - 1)][s] = 1'b1;
            for (int d = 0; d < D; d++)
                bus.des_resp_vld_i[d] = (bank_q[d].size() > 0) &&
                    (c >= 40 || $urandom_range(0, 3) != 0);
            bus.out_rdy_i = (c >= 40) ? 2'b11 : 2'($urandom);
            @(negedge clk);
            model_out(mv, mr, mp);
            checks++;
            if (bus.alloc_rdy_o !== (exp_q.size() <= DP - S)) begin
                fails++;
                $display("FAIL rand_alloc_rdy c%0d got %b cnt %0d",
                         c, bus.alloc_rdy_o, exp_q.size());
            end
            checks++;
            if (bus.out_vld_o !== mv || bus.des_resp_rdy_o !== mr) begin
                fails++;
                $display("FAIL rand_vld c%0d vld %b rdy %b want %b %b",
                         c, bus.out_vld_o, bus.des_resp_rdy_o, mv, mr);
            end
            for (int k = 0; k < O; k++) begin
                if (mv[k]) begin
                    checks++;
                    if (bus.out_des_o[k] !== exp_q[k].des ||
                        bus.out_data_o[k] !== exp_q[k].data) begin
                        fails++;
                        bad++;
                        $display("FAIL rand_order c%0d lane %0d got %0d/%h want %0d/%h",
                                 c, k, bus.out_des_o[k], bus.out_data_o[k],
                                 exp_q[k].des, exp_q[k].data);
                    end
                end
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (bus.out_vld_o !== 2'b00 || exp_q.size() != 0 || tag < DP + 1) begin
            fails++;
            $display("FAIL rand_end vld %b left %0d pushed %0d",
                     bus.out_vld_o, exp_q.size(), tag);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_alloc(4'b1111, 0, 1, 2, 3);
        tick();
        set_alloc(4'b0000, -1, -1, -1, -1);
        bus.des_resp_vld_i = 4'b1111;
        bus.out_rdy_i      = 2'b00;
        #2;
        rst = 1'b0;
        clear_model();
        #1;
        checks++;
        if (bus.out_vld_o !== 2'b00 || bus.des_resp_rdy_o !== 4'b0000 ||
            bus.alloc_rdy_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid vld %b rdy %b alloc_rdy %b want 00 0000 1",
                     bus.out_vld_o, bus.des_resp_rdy_o, bus.alloc_rdy_o);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (bus.out_vld_o !== 2'b00) begin
            fails++;
            $display("FAIL reset_mid_after vld %b want 00", bus.out_vld_o);
        end
        bus.des_resp_vld_i = 4'b0000;
    endtask

`ifdef INORDER_RESP_MERGER_ERR_CHK_EN
    task automatic test_err();
        do_reset();
        checks++;
        if (err_o !== 1'b0) begin
            fails++;
            $display("FAIL err_reset got %b want 0", err_o);
        end
        bus.des_resp_vld_i = 4'b1000;
        @(negedge clk);
        checks++;
        if (err_o !== 1'b0 || bus.out_vld_o !== 2'b00) begin
            fails++;
            $display("FAIL err_pre got %b vld %b want 0 00", err_o, bus.out_vld_o);
        end
        tick();
        bus.des_resp_vld_i = 4'b0000;
        checks++;
        if (err_o !== 1'b1) begin
            fails++;
            $display("FAIL err_set got %b want 1", err_o);
        end
        repeat (3) tick();
        checks++;
        if (err_o !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky got %b want 1", err_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            fails++;
            $display("FAIL err_clear got %b want 0", err_o);
        end
        do_reset();
    endtask
`endif

    initial begin
        clear_inputs();
        refresh_data();
        test_reset();
        test_basic();
        test_same_bank();
        test_head_block();
        test_full();
        test_random();
        test_reset_mid();
`ifdef INORDER_RESP_MERGER_ERR_CHK_EN
        test_err();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule

// File: doc/inorder_resp_merger.md
Name: inorder_resp_merger

Overview:
- Return-path companion to the in-order dispatch router.
- Records, in program order, which destination (bank) each dispatched source request went to, then collects bank responses and re-emits them in original program order, up to OUT_COUNT per cycle.
- Sits between the L1D banks' response ports and the LSU writeback path. Each bank returns its own responses in order; banks are mutually unordered.

Parameters:
- SRC_COUNT, 4, dispatch lanes per cycle (matches router SRC_COUNT).
- DES_COUNT, 4, number of destinations/banks (matches router DES_COUNT).
- OUT_COUNT, 2, in-order output lanes per cycle; must be <= DES_COUNT.
- DEPTH, 16, order-FIFO entries; power of two, >= SRC_COUNT.
- DATA_W, 64, response payload width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- alloc_vld_i  in  SRC_COUNT  source lane dispatched this cycle (router success vector).
- alloc_des_sel_i  in  DES_COUNT x SRC_COUNT  router selection matrix, [des][src]; at most one des per src column.
- alloc_rdy_o  out  1  free entries >= SRC_COUNT.
- des_resp_vld_i  in  DES_COUNT  bank response valid.
- des_resp_data_i  in  DES_COUNT x DATA_W  bank response payload.
- des_resp_rdy_o  out  DES_COUNT  bank response consumed this cycle.
- out_vld_o  out  OUT_COUNT  in-order output lane valid; prefix-contiguous.
- out_data_o  out  OUT_COUNT x DATA_W  output payload.
- out_des_o  out  OUT_COUNT x clog2(DES_COUNT)  originating bank index.
- out_rdy_i  in  OUT_COUNT  consumer ready per lane.

Behaviour:
- Order FIFO:
  - DEPTH entries, each holding a bank index.
  - head/tail pointers are clog2(DEPTH)+1 bits with a wrap bit; occupancy counter cnt.
  - On reset: head=tail=cnt=0, so alloc_rdy_o=1, out_vld_o=0, des_resp_rdy_o=0.
- Allocation:
  - Push occurs only when alloc_rdy_o=1. When alloc_rdy_o=0, alloc inputs are ignored; the upstream router must stall.
  - alloc_rdy_o depends only on the registered cnt, not on same-cycle pops.
  - Scan src lanes 0..SRC_COUNT-1 in ascending order. A lane with alloc_vld_i=1 and exactly one selected des pushes that des index at the next tail slot; pushes are compacted.
  - A lane with vld=1 but no selected des is skipped, with no push.
  - Push count is 0..SRC_COUNT; tail advances by the push count, modulo DEPTH with wrap toggle.
- Output, combinational, zero latency from des_resp_vld_i:
  - Lane k looks at FIFO entry head+k with bank b_k.
  - out_vld_o[k]=1 iff all of: k<cnt; des_resp_vld_i[b_k]=1; b_k differs from b_0..b_{k-1}; out_vld_o[k-1]=1 (for k>0).
  - A repeated bank ends the valid prefix, since each bank supplies one response per cycle.
  - out_data_o[k]=des_resp_data_i[b_k] and out_des_o[k]=b_k. Both are don't-care when out_vld_o[k]=0.
- Pop:
  - Lane k fires iff out_vld_o[k] & out_rdy_i[k] and lanes 0..k-1 all fire.
  - pop = number of firing lanes; head advances by pop.
  - des_resp_rdy_o[b]=1 iff a firing lane has b_k=b.
- Counter update: cnt_next = cnt + push - pop. Simultaneous push and pop are legal in the same cycle, including when cnt=0 (a new push is not visible to output until the next cycle).
- Boundaries:
  - Empty: all out_vld_o=0 and all des_resp_rdy_o=0.
  - Full or near full (cnt > DEPTH-SRC_COUNT): alloc_rdy_o=0.
  - Pointer wrap at DEPTH is seamless.
  - Reset asserted mid-operation discards all outstanding entries immediately (asynchronous).

Optional Feature:
- Macro: INORDER_RESP_MERGER_ERR_CHK_EN.
- With the macro defined:
  - Per-bank outstanding counter (clog2(DEPTH)+1 bits): +1 per push to that bank, -1 per pop from it, reset 0.
  - Output port err_o (1 bit) is added.
  - err_o is set, sticky until reset, when either:
    - des_resp_vld_i[b]=1 while bank b's outstanding counter is 0;
    - more than one selected des appears in a single alloc_des_sel_i column.
  - err_o resets to 0.
- Without the macro: no counters and no err_o port; behaviour is otherwise identical.

Test Plan:
- Reset, then alloc lanes 0..3 to banks 2,0,1,3; all bank responses valid; out_rdy=2'b11 -> cycle 1: out_des=2,0; cycle 2: out_des=1,3; cnt returns to 0.
- Entries banks 1,1 with bank 1 valid, out_rdy=11 -> only out_vld=01; second entry pops next cycle.
- Head bank 2 not valid, bank 0 (entry 1) valid -> out_vld=00; bank 0 des_resp_rdy=0 until bank 2 responds.
- Fill until cnt=13 (DEPTH=16) -> alloc_rdy_o=0 and a further alloc is ignored; pop 2 -> cnt=11 -> alloc_rdy_o=1.
- 40 cycles of random alloc/resp with wrap past DEPTH -> output order equals alloc order exactly; scoreboard shows no loss or duplication.
- ERR_CHK_EN: bank 3 resp_vld with no outstanding entry -> err_o=1 next cycle and stays 1 until rst low.
